neuron_feed_sequencer: RTL and testbench

Drives the accumulation register from the producer side. For each neuron of a layer it streams input activations and weights out of on-chip memories, forms saturated Q8.8 products, and presents them as `partial_sum` with a one-cycle `add_done` strobe per product. After a neuron's last product it issues a one-cycle `neuron_done`. It sits between the activation/weight RAMs and the accumulator in the accelerator datapath.

---
 rtl/neuron_feed_sequencer_if.sv | 29 ++
 rtl/neuron_feed_sequencer.sv | 102 ++++++++++
 tb/tb_neuron_feed_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/neuron_feed_sequencer_if.sv
// neuron_feed_sequencer_if: memory-read and product-stream signals of the feed sequencer.
// master = sequencer side, slave = memories/accumulator/controller side.
interface neuron_feed_sequencer_if #(
    parameter int AW = 8,
    parameter int NW = 2
);
    logic                 start;
    logic [AW-1:0]        in_addr;
    logic [AW-1:0]        w_addr;
    logic                 rd_en;
    logic signed [15:0]   in_data;
    logic signed [15:0]   w_data;
    logic [15:0]          partial_sum;
    logic                 add_done;
    logic                 neuron_done;
    logic [NW-1:0]        neuron_idx;
    logic                 busy;
    logic                 layer_done;
    modport master (
        input  start, in_data, w_data,
        output in_addr, w_addr, rd_en, partial_sum, add_done,
               neuron_done, neuron_idx, busy, layer_done
    );
    modport slave (
        output start, in_data, w_data,
        input  in_addr, w_addr, rd_en, partial_sum, add_done,
               neuron_done, neuron_idx, busy, layer_done
    );
endinterface

// File: rtl/neuron_feed_sequencer.sv
// neuron_feed_sequencer: streams activation/weight pairs per neuron and emits saturated Q-format products.
// Optional ROUND_EN macro switches the product shift from floor truncation to round-half-up.
module neuron_feed_sequencer #(
    parameter int N_INPUTS  = 16,
    parameter int N_NEURONS = 4,
    parameter int FRAC      = 8,
    parameter int AW        = 8,
    parameter int NW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input logic                      clk,
    input logic                      reset,
    neuron_feed_sequencer_if.master  bus
);
    typedef enum logic [2:0] {IDLE, STREAM, DRAIN1, DRAIN2, FINISH} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      i_q, i_d, w_q, w_d;
    logic [NW-1:0]      n_q, n_d;
    logic               v_q, v_d, add_q, add_d;
    logic [15:0]        ps_q, ps_d;
    logic               last_i, last_n;
    logic signed [31:0] prod, shifted;
    logic [15:0]        sat;

    assign last_i = i_q == AW'(N_INPUTS - 1);
    assign last_n = n_q == NW'(N_NEURONS - 1);

    // Counters are only rewritten when entering or advancing STREAM, so addresses hold while rd_en is low.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        w_d     = w_q;
        n_d     = n_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = STREAM;
                i_d     = '0;
                w_d     = '0;
                n_d     = '0;
            end
            STREAM: if (last_i) state_d = DRAIN1;
                    else begin
                        i_d = i_q + 1'b1;
                        w_d = w_q + 1'b1;
                    end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: state_d = FINISH;
            FINISH: begin
                state_d = last_n ? IDLE : STREAM;
                n_d     = last_n ? '0 : n_q + 1'b1;
                i_d     = last_n ? i_q : '0;
                w_d     = last_n ? w_q : w_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign prod = bus.in_data * bus.w_data;
`ifdef ROUND_EN
    assign shifted = (prod + (32'sd1 <<< (FRAC - 1))) >>> FRAC;
`else
    assign shifted = prod >>> FRAC;
`endif
    assign sat = shifted > 32'sd32767  ? 16'h7FFF :
                 shifted < -32'sd32768 ? 16'h8000 : shifted[15:0];

    always_comb begin
        v_d   = state_q == STREAM;
        add_d = v_q;
        ps_d  = v_q ? sat : ps_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            w_q     <= '0;
            n_q     <= '0;
            v_q     <= 1'b0;
            add_q   <= 1'b0;
            ps_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            w_q     <= w_d;
            n_q     <= n_d;
            v_q     <= v_d;
            add_q   <= add_d;
            ps_q    <= ps_d;
        end
    end

    assign bus.rd_en       = state_q == STREAM;
    assign bus.in_addr     = i_q;
    assign bus.w_addr      = w_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.neuron_done = state_q == FINISH;
    assign bus.layer_done  = state_q == FINISH && last_n;
    assign bus.neuron_idx  = n_q;
    assign bus.partial_sum = ps_q;
    assign bus.add_done    = add_q;
endmodule

// File: tb/tb_neuron_feed_sequencer.sv
// tb_neuron_feed_sequencer: directed checks of timing, saturation, rounding, multi-neuron and reset behaviour.
module tb_neuron_feed_sequencer;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    logic [15:0] act_a [256];
    logic [15:0] wt_a  [256];
    logic [15:0] act_b [256];
    logic [15:0] wt_b  [256];

    always #5 clk = ~clk;

    neuron_feed_sequencer_if #(.AW(8), .NW(1)) if_a ();
    neuron_feed_sequencer_if #(.AW(8), .NW(2)) if_b ();

    neuron_feed_sequencer #(.N_INPUTS(4), .N_NEURONS(1), .FRAC(8), .AW(8)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.master));
    neuron_feed_sequencer #(.N_INPUTS(3), .N_NEURONS(3), .FRAC(8), .AW(8)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.master));

    always @(posedge clk) begin
        if (if_a.rd_en) begin
            if_a.in_data <= act_a[if_a.in_addr];
            if_a.w_data  <= wt_a[if_a.w_addr];
        end
        if (if_b.rd_en) begin
            if_b.in_data <= act_b[if_b.in_addr];
            if_b.w_data  <= wt_b[if_b.w_addr];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, " rd_en"}, if_a.rd_en, 0);
        chk({tag, " busy"}, if_a.busy, 0);
        chk({tag, " add_done"}, if_a.add_done, 0);
        chk({tag, " partial_sum"}, if_a.partial_sum, 0);
        chk({tag, " in_addr"}, if_a.in_addr, 0);
        chk({tag, " w_addr"}, if_a.w_addr, 0);
        chk({tag, " neuron_done"}, if_a.neuron_done, 0);
        chk({tag, " layer_done"}, if_a.layer_done, 0);
        chk({tag, " neuron_idx"}, if_a.neuron_idx, 0);
    endtask

    // One 4-input, 1-neuron layer; start is sampled at the edge right after this task begins.
    task automatic run_a(input string tag, input logic [15:0] e0, e1, e2, e3, input bit poke);
        logic [15:0] e [4];
        e = '{e0, e1, e2, e3};
        if_a.start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if_a.start = poke && (k == 2 || k == 6);
            chk($sformatf("%s rd_en T+%0d", tag, k), if_a.rd_en, k <= 4);
            chk($sformatf("%s busy T+%0d", tag, k), if_a.busy, k <= 7);
            chk($sformatf("%s add_done T+%0d", tag, k), if_a.add_done, k >= 3 && k <= 6);
            chk($sformatf("%s neuron_done T+%0d", tag, k), if_a.neuron_done, k == 7);
            chk($sformatf("%s layer_done T+%0d", tag, k), if_a.layer_done, k == 7);
            if (k <= 4) begin
                chk($sformatf("%s in_addr T+%0d", tag, k), if_a.in_addr, k - 1);
                chk($sformatf("%s w_addr T+%0d", tag, k), if_a.w_addr, k - 1);
            end
            if (k >= 3 && k <= 6)
                chk($sformatf("%s partial_sum T+%0d", tag, k), if_a.partial_sum, e[k-3]);
            if (k >= 7) begin
                chk($sformatf("%s ps hold T+%0d", tag, k), if_a.partial_sum, e[3]);
                chk($sformatf("%s addr hold T+%0d", tag, k), if_a.in_addr, 3);
            end
        end
    endtask

    initial begin
        logic [15:0] r_pos, r_neg, r_m15;
`ifdef ROUND_EN
        r_pos = 16'h0001; r_neg = 16'h0000; r_m15 = 16'hFFFF;
`else
        r_pos = 16'h0000; r_neg = 16'hFFFF; r_m15 = 16'hFFFE;
`endif
        reset = 1'b0;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        repeat (3) tick();
        chk_idle_a("reset");
        chk("reset b busy", if_b.busy, 0);
        chk("reset b rd_en", if_b.rd_en, 0);
        reset = 1'b1;
        tick();
        chk_idle_a("post-reset idle");

        for (int j = 0; j < 4; j++) begin
            act_a[j] = 16'h0200;
            wt_a[j]  = 16'h0180;
        end
        run_a("basic", 16'h0300, 16'h0300, 16'h0300, 16'h0300, 1'b0);

        act_a[0] = 16'h7F00; wt_a[0] = 16'h0400;
        act_a[1] = 16'h8000; wt_a[1] = 16'h0400;
        act_a[2] = 16'h8000; wt_a[2] = 16'h8000;
        act_a[3] = 16'h0001; wt_a[3] = 16'h0080;
        run_a("sat", 16'h7FFF, 16'h8000, 16'h7FFF, r_pos, 1'b0);

        act_a[0] = 16'hFFFF; wt_a[0] = 16'h0080;
        act_a[1] = 16'h0100; wt_a[1] = 16'hFF00;
        act_a[2] = 16'h0300; wt_a[2] = 16'h0050;
        act_a[3] = 16'hFFFF; wt_a[3] = 16'h0180;
        run_a("round+poke", r_neg, 16'hFF00, 16'h00F0, r_m15, 1'b1);

        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        repeat (3) tick();
        chk("mid T+4 rd_en", if_a.rd_en, 1);
        chk("mid T+4 in_addr", if_a.in_addr, 3);
        chk("mid T+4 add_done", if_a.add_done, 1);
        reset = 1'b0;
        tick();
        chk_idle_a("mid reset T+5");
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("aborted neuron_done +%0d", k), if_a.neuron_done, 0);
            chk($sformatf("aborted busy +%0d", k), if_a.busy, 0);
        end
        run_a("replay", r_neg, 16'hFF00, 16'h00F0, r_m15, 1'b0);

        for (int j = 0; j < 9; j++) begin
            act_b[j] = 16'h0100;
            wt_b[j]  = 16'((j + 1) * 256);
        end
        if_b.start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            int n, ph;
            tick();
            if_b.start = 1'b0;
            n  = (k - 1) / 6;
            ph = (k - 1) % 6 + 1;
            if (k <= 18) begin
                chk($sformatf("multi rd_en T+%0d", k), if_b.rd_en, ph <= 3);
                chk($sformatf("multi neuron_idx T+%0d", k), if_b.neuron_idx, n);
                chk($sformatf("multi neuron_done T+%0d", k), if_b.neuron_done, ph == 6);
                chk($sformatf("multi layer_done T+%0d", k), if_b.layer_done, k == 18);
                chk($sformatf("multi busy T+%0d", k), if_b.busy, 1);
                chk($sformatf("multi add_done T+%0d", k), if_b.add_done, ph >= 3 && ph <= 5);
                if (ph <= 3) begin
                    chk($sformatf("multi w_addr T+%0d", k), if_b.w_addr, n * 3 + ph - 1);
                    chk($sformatf("multi in_addr T+%0d", k), if_b.in_addr, ph - 1);
                end
                if (ph >= 3 && ph <= 5)
                    chk($sformatf("multi partial_sum T+%0d", k), if_b.partial_sum, (n * 3 + ph - 2) * 256);
            end else begin
                chk("multi busy end", if_b.busy, 0);
                chk("multi rd_en end", if_b.rd_en, 0);
                chk("multi neuron_idx end", if_b.neuron_idx, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
